// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified memory port arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_FETCH   = 2'd1,
        ARB_DATA    = 2'd2,
        ARB_DISCARD = 2'd3
    } arb_state_t;

    localparam int unsigned RUN_CNT_W = 4;
    localparam logic [3:0]  FETCH_BE  = 4'hF;

endpackage

// File: rtl/mem_arb_select.sv
// Combinational eligibility and priority picker for the memory port arbiter.
module mem_arb_select
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned MAX_DATA_RUN = 4
)
(
    input  logic                 is_idle,
    input  logic                 if_req,
    input  logic                 flush,
    input  logic                 instr_valid,
    input  logic                 dm_req,
    input  logic                 dm_valid,
    input  logic [RUN_CNT_W-1:0] run_cnt,
    output logic                 grant_fetch,
    output logic                 grant_data,
    output logic                 run_below_max
);

    localparam logic [RUN_CNT_W-1:0] MAX_RUN_C = RUN_CNT_W'(MAX_DATA_RUN);

    logic fetch_elig_s;
    logic data_elig_s;

    // A requester whose result pulses this cycle is already served; fetch is ignored while flushing.
    always_comb begin
        fetch_elig_s  = if_req & ~flush & ~instr_valid;
        data_elig_s   = dm_req & ~dm_valid;
        run_below_max = (run_cnt < MAX_RUN_C);
        grant_fetch   = 1'b0;
        grant_data    = 1'b0;
        if (is_idle && data_elig_s && (run_below_max || !fetch_elig_s)) begin
            grant_data = 1'b1;
        end else if (is_idle && fetch_elig_s) begin
            grant_fetch = 1'b1;
        end else begin
            grant_fetch = 1'b0;
            grant_data  = 1'b0;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and data accesses,
// holding each grant through a variable-latency ready handshake.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned MAX_DATA_RUN = 4
)
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        IF_Req,
    input  logic [31:0] IF_Addr,
    input  logic        Flush,
    input  logic        DM_Req,
    input  logic        DM_We,
    input  logic [31:0] DM_Addr,
    input  logic [31:0] DM_WData,
    input  logic [3:0]  DM_Be,
    output logic        Mem_Req,
    output logic        Mem_We,
    output logic [31:0] Mem_Addr,
    output logic [31:0] Mem_WData,
    output logic [3:0]  Mem_Be,
    input  logic        Mem_Ready,
    input  logic [31:0] Mem_RData,
    output logic        Instr_Valid,
    output logic [31:0] Instr_F,
    output logic        DM_Valid,
    output logic [31:0] DM_RData,
    output logic        Stall_F,
    output logic        Stall_M
);

    arb_state_t           state_r;
    arb_state_t           state_nxt_s;
    logic [RUN_CNT_W-1:0] run_cnt_r;
    logic                 is_idle_s;
    logic                 grant_fetch_s;
    logic                 grant_data_s;
    logic                 run_below_max_s;
    logic                 instr_load_s;
    logic                 data_done_s;
    logic                 access_done_s;

    assign is_idle_s     = (state_r == ARB_IDLE);
    assign access_done_s = ~is_idle_s & Mem_Ready;
    assign Stall_F       = IF_Req & ~Instr_Valid;
    assign Stall_M       = DM_Req & ~DM_Valid;

    mem_arb_select #(
        .MAX_DATA_RUN (MAX_DATA_RUN)
    ) u_select (
        .is_idle       (is_idle_s),
        .if_req        (IF_Req),
        .flush         (Flush),
        .instr_valid   (Instr_Valid),
        .dm_req        (DM_Req),
        .dm_valid      (DM_Valid),
        .run_cnt       (run_cnt_r),
        .grant_fetch   (grant_fetch_s),
        .grant_data    (grant_data_s),
        .run_below_max (run_below_max_s)
    );

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r <= ARB_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state plus result-capture strobes; a redirect turns an in-flight fetch into a discard.
    always_comb begin
        state_nxt_s  = state_r;
        instr_load_s = 1'b0;
        data_done_s  = 1'b0;
        case (state_r)
            ARB_IDLE: begin
                if (grant_data_s) begin
                    state_nxt_s = ARB_DATA;
                end else if (grant_fetch_s) begin
                    state_nxt_s = ARB_FETCH;
                end else begin
                    state_nxt_s = ARB_IDLE;
                end
            end
            ARB_FETCH: begin
                if (Mem_Ready) begin
                    state_nxt_s  = ARB_IDLE;
                    instr_load_s = ~Flush;
                end else if (Flush) begin
                    state_nxt_s = ARB_DISCARD;
                end else begin
                    state_nxt_s = ARB_FETCH;
                end
            end
            ARB_DATA: begin
                if (Mem_Ready) begin
                    state_nxt_s = ARB_IDLE;
                    data_done_s = 1'b1;
                end else begin
                    state_nxt_s = ARB_DATA;
                end
            end
            ARB_DISCARD: begin
                if (Mem_Ready) begin
                    state_nxt_s = ARB_IDLE;
                end else begin
                    state_nxt_s = ARB_DISCARD;
                end
            end
            default: begin
                state_nxt_s = ARB_IDLE;
            end
        endcase
    end

    // Consecutive data grants while a fetch is waiting; saturates at the cap.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            run_cnt_r <= {RUN_CNT_W{1'b0}};
        end else if (!IF_Req || grant_fetch_s) begin
            run_cnt_r <= {RUN_CNT_W{1'b0}};
        end else if (grant_data_s && run_below_max_s) begin
            run_cnt_r <= run_cnt_r + {{(RUN_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            run_cnt_r <= run_cnt_r;
        end
    end

    // Memory request registers: loaded on grant, held until the access completes.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            Mem_Req   <= 1'b0;
            Mem_We    <= 1'b0;
            Mem_Addr  <= 32'd0;
            Mem_WData <= 32'd0;
            Mem_Be    <= 4'd0;
        end else if (grant_data_s) begin
            Mem_Req   <= 1'b1;
            Mem_We    <= DM_We;
            Mem_Addr  <= DM_Addr;
            Mem_WData <= DM_WData;
            Mem_Be    <= DM_Be;
        end else if (grant_fetch_s) begin
            Mem_Req   <= 1'b1;
            Mem_We    <= 1'b0;
            Mem_Addr  <= IF_Addr;
            Mem_WData <= 32'd0;
            Mem_Be    <= FETCH_BE;
        end else if (access_done_s) begin
            Mem_Req   <= 1'b0;
            Mem_We    <= 1'b0;
        end
    end

    // Result registers; store completions leave DM_RData untouched.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            Instr_Valid <= 1'b0;
            Instr_F     <= 32'd0;
            DM_Valid    <= 1'b0;
            DM_RData    <= 32'd0;
        end else begin
            Instr_Valid <= instr_load_s;
            DM_Valid    <= data_done_s;
            if (instr_load_s) begin
                Instr_F <= Mem_RData;
            end
            if (data_done_s && !Mem_We) begin
                DM_RData <= Mem_RData;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized bench for mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int MAX_RUN = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'd0;
    logic        flush = 1'b0;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [31:0] dm_addr = 32'd0;
    logic [31:0] dm_wdata = 32'd0;
    logic [3:0]  dm_be = 4'd0;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_req, mem_we, instr_valid, dm_valid, stall_f, stall_m;
    logic [31:0] mem_addr, mem_wdata, instr_f, dm_rdata;
    logic [3:0]  mem_be;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MAX_DATA_RUN(MAX_RUN)) dut (
        .CLK(clk), .RST(rst), .IF_Req(if_req), .IF_Addr(if_addr), .Flush(flush),
        .DM_Req(dm_req), .DM_We(dm_we), .DM_Addr(dm_addr), .DM_WData(dm_wdata), .DM_Be(dm_be),
        .Mem_Req(mem_req), .Mem_We(mem_we), .Mem_Addr(mem_addr), .Mem_WData(mem_wdata),
        .Mem_Be(mem_be), .Mem_Ready(mem_ready), .Mem_RData(mem_rdata),
        .Instr_Valid(instr_valid), .Instr_F(instr_f), .DM_Valid(dm_valid), .DM_RData(dm_rdata),
        .Stall_F(stall_f), .Stall_M(stall_m)
    );

    // Reference model: one outstanding access with an owner, plus expected registered outputs.
    bit          m_busy, m_data_owner, m_stale;
    int          m_run, m_cnt, m_lat;
    int          lat_mode;
    logic [31:0] rd_val;
    logic        e_req, e_we, e_iv, e_dv;
    logic [31:0] e_addr, e_wdata, e_instr, e_drdata;
    logic [3:0]  e_be;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0; m_data_owner = 1'b0; m_stale = 1'b0;
        m_run = 0; m_cnt = 0; m_lat = 0;
        e_req = 1'b0; e_we = 1'b0; e_iv = 1'b0; e_dv = 1'b0;
        e_addr = 32'd0; e_wdata = 32'd0; e_instr = 32'd0; e_drdata = 32'd0; e_be = 4'd0;
    endtask

    task automatic check_outputs();
        chk("mem_req", mem_req, e_req);
        if (e_req) begin
            chk("mem_we", mem_we, e_we);
            chk("mem_addr", mem_addr, e_addr);
            chk("mem_wdata", mem_wdata, e_wdata);
            chk("mem_be", mem_be, e_be);
        end
        chk("instr_valid", instr_valid, e_iv);
        chk("instr_f", instr_f, e_instr);
        chk("dm_valid", dm_valid, e_dv);
        chk("dm_rdata", dm_rdata, e_drdata);
    endtask

    // One clock cycle: called at a falling edge with the request inputs already driven.
    task automatic tick();
        bit fe, de, gd, gf, n_iv, n_dv;
        check_outputs();
        mem_ready = m_busy && (m_cnt >= m_lat);
        mem_rdata = rd_val;
        #1;
        chk("stall_f", stall_f, if_req && !e_iv);
        chk("stall_m", stall_m, dm_req && !e_dv);
        gd = 1'b0; gf = 1'b0; n_iv = 1'b0; n_dv = 1'b0;
        if (m_busy) begin
            if (mem_ready) begin
                if (m_data_owner) begin
                    n_dv = 1'b1;
                    if (!e_we) e_drdata = mem_rdata;
                end else if (!m_stale && !flush) begin
                    n_iv = 1'b1;
                    e_instr = mem_rdata;
                end
                m_busy = 1'b0; e_req = 1'b0; e_we = 1'b0;
            end else if (!m_data_owner && flush) begin
                m_stale = 1'b1;
            end
        end else begin
            fe = if_req && !flush && !e_iv;
            de = dm_req && !e_dv;
            gd = de && (m_run < MAX_RUN || !fe);
            gf = fe && !gd;
            if (gd) begin
                m_busy = 1'b1; m_data_owner = 1'b1; m_stale = 1'b0;
                e_req = 1'b1; e_we = dm_we; e_addr = dm_addr; e_wdata = dm_wdata; e_be = dm_be;
            end
            if (gf) begin
                m_busy = 1'b1; m_data_owner = 1'b0; m_stale = 1'b0;
                e_req = 1'b1; e_we = 1'b0; e_addr = if_addr; e_wdata = 32'd0; e_be = 4'hF;
            end
        end
        if (!if_req || gf) m_run = 0;
        else if (gd && m_run < MAX_RUN) m_run++;
        if (gd || gf) begin
            m_cnt = 0;
            m_lat = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
        end else if (m_busy) begin
            m_cnt++;
        end
        e_iv = n_iv;
        e_dv = n_dv;
        @(negedge clk);
    endtask

    task automatic settle();
        if_req = 1'b0; dm_req = 1'b0; flush = 1'b0;
        for (int i = 0; i < 8; i++) tick();
    endtask

    logic [31:0] prev_rd;

    initial begin
        model_reset();
        lat_mode = 0;
        rd_val = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_instr_valid", instr_valid, 1'b0);
        chk("rst_dm_valid", dm_valid, 1'b0);
        chk("rst_mem_be", mem_be, 4'h0);
        rst = 1'b0;

        // Fetch only, ready two cycles after the request.
        if_req = 1'b1; if_addr = 32'h10; lat_mode = 2; rd_val = 32'h0050_0093;
        for (int i = 0; i < 12 && !instr_valid; i++) tick();
        chk("t1_valid", instr_valid, 1'b1);
        chk("t1_instr", instr_f, 32'h0050_0093);
        if_req = 1'b0;
        tick();
        tick();

        // Simultaneous requests: data goes first.
        if_req = 1'b1; if_addr = 32'h20; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200;
        dm_wdata = 32'h0; dm_be = 4'hF; lat_mode = 0; rd_val = 32'h1122_3344;
        tick();
        chk("t2_data_first_addr", mem_addr, 32'h200);
        chk("t2_data_first_we", mem_we, 1'b0);
        rd_val = 32'h5566_7788;
        for (int i = 0; i < 6; i++) tick();
        settle();

        // Data run cap: flushing keeps fetch out until the run saturates.
        if_req = 1'b1; if_addr = 32'h40; dm_req = 1'b1; dm_addr = 32'h240; flush = 1'b1;
        rd_val = 32'h0BAD_F00D;
        for (int i = 0; i < 40; i++) begin
            if (m_run == MAX_RUN && !m_busy && !e_dv) break;
            tick();
        end
        flush = 1'b0;
        tick();
        chk("t3_capped_fetch_addr", mem_addr, 32'h40);
        chk("t3_capped_fetch_be", mem_be, 4'hF);
        settle();

        // Redirect one cycle into a four-cycle fetch.
        if_req = 1'b1; if_addr = 32'h80; lat_mode = 3; rd_val = 32'hAAAA_5555;
        tick();
        tick();
        flush = 1'b1; if_addr = 32'hC0;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 6 && m_busy; i++) tick();
        chk("t4_no_valid", instr_valid, 1'b0);
        tick();
        chk("t4_new_addr", mem_addr, 32'hC0);
        settle();

        // Store with partial byte enables; load data register must hold.
        prev_rd = e_drdata;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h300; dm_wdata = 32'hDEAD_BEEF; dm_be = 4'b0011;
        lat_mode = 1; rd_val = 32'h1234_5678;
        tick();
        dm_wdata = 32'h0;
        chk("t5_we", mem_we, 1'b1);
        chk("t5_be", mem_be, 4'h3);
        chk("t5_wdata", mem_wdata, 32'hDEAD_BEEF);
        tick();
        tick();
        chk("t5_dm_valid", dm_valid, 1'b1);
        chk("t5_drdata_kept", dm_rdata, prev_rd);
        settle();

        // Asynchronous reset in the middle of a data access.
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h340; lat_mode = 3;
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        chk("t6_mem_req", mem_req, 1'b0);
        chk("t6_mem_we", mem_we, 1'b0);
        chk("t6_mem_addr", mem_addr, 32'h0);
        chk("t6_mem_wdata", mem_wdata, 32'h0);
        chk("t6_mem_be", mem_be, 4'h0);
        chk("t6_instr_valid", instr_valid, 1'b0);
        chk("t6_instr_f", instr_f, 32'h0);
        chk("t6_dm_valid", dm_valid, 1'b0);
        chk("t6_dm_rdata", dm_rdata, 32'h0);
        model_reset();
        mem_ready = 1'b0; dm_req = 1'b0; if_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Randomized traffic against the model.
        lat_mode = -1;
        for (int i = 0; i < 600; i++) begin
            if_req   = ($urandom_range(0, 3) != 0);
            if_addr  = $urandom & 32'hFFFF_FFFC;
            flush    = ($urandom_range(0, 7) == 0);
            dm_req   = ($urandom_range(0, 2) != 0);
            dm_we    = 1'($urandom_range(0, 1));
            dm_addr  = $urandom & 32'hFFFF_FFFC;
            dm_wdata = $urandom;
            dm_be    = 4'($urandom_range(0, 15));
            rd_val   = $urandom;
            tick();
        end
        settle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
